minirisc_exec_p: RTL

MINIRISC_EXEC_P -- requirements
Module: minirisc_exec_p

---
 rtl/minirisc_pkg.sv | 27 ++
 rtl/minirisc_mul_seq.sv | 52 +++++
 rtl/minirisc_exec_p.sv | 134 +++++++++++++
 3 files changed

// File: rtl/minirisc_pkg.sv
// Shared types and legal parameter ranges for the minirisc execution block.
package minirisc_pkg;

  typedef enum logic [3:0] {
    OpNop = 4'd0,
    OpLi  = 4'd1,
    OpAdd = 4'd2,
    OpSub = 4'd3,
    OpAnd = 4'd4,
    OpOr  = 4'd5,
    OpXor = 4'd6,
    OpShl = 4'd7,
    OpMul = 4'd8,
    OpOut = 4'd9
  } op_e;

  typedef enum logic {
    StIdle    = 1'b0,
    StMulBusy = 1'b1
  } state_e;

  localparam int unsigned DataWMin = 4;
  localparam int unsigned DataWMax = 32;
  localparam int unsigned NregsMin = 2;
  localparam int unsigned NregsMax = 16;

endpackage

// File: rtl/minirisc_mul_seq.sv
// Shift-add multiplier: operands latched on start, result valid with done
// on the DATA_W-th cycle after start (product is the low DATA_W bits).
module minirisc_mul_seq #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int unsigned CntW = $clog2(DATA_W);

  logic              running_q;
  logic [DATA_W-1:0] a_q, b_q, acc_q;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] acc_next;

  // One partial-product step; the final step's sum is presented as product.
  always_comb begin
    acc_next = b_q[0] ? (acc_q + a_q) : acc_q;
    done     = running_q && (cnt_q == CntW'(DATA_W - 1));
    product  = acc_next;
  end

  // Operand shift registers, accumulator and step counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else if (start) begin
      running_q <= 1'b1;
      a_q       <= op_a;
      b_q       <= op_b;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else if (running_q) begin
      acc_q <= acc_next;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + 1'b1;
      if (done) running_q <= 1'b0;
    end
  end

endmodule

// File: rtl/minirisc_exec_p.sv
// Minirisc execution unit: register file, single-cycle ALU ops, output port
// and a multi-cycle multiply that stalls the instruction handshake.
module minirisc_exec_p
  import minirisc_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREGS  = 4,
  localparam int unsigned RIDX_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [RIDX_W-1:0] in_rd,
  input  logic [RIDX_W-1:0] in_rs,
  input  logic [DATA_W-1:0] in_imm,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              flag_z,
  output logic              flag_c,
  output logic              busy,
  output logic              err
);

  if (DATA_W < DataWMin || DATA_W > DataWMax || NREGS < NregsMin || NREGS > NregsMax ||
      (NREGS & (NREGS - 1)) != 0) begin : g_bad_param
    $error("minirisc_exec_p: DATA_W or NREGS outside legal range");
  end

  state_e            state_q, state_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              z_q, z_d, c_q, c_d, err_q, err_d;
  logic [RIDX_W-1:0] mul_rd_q;

  logic              wr_en;
  logic [RIDX_W-1:0] wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_val, rs_val;
  logic [DATA_W:0]   sum, diff;
  logic              accept, mul_start, mul_done;
  logic [DATA_W-1:0] mul_product;

  minirisc_mul_seq #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .op_a    (rd_val),
    .op_b    (rs_val),
    .done    (mul_done),
    .product (mul_product)
  );

  // Decode, ALU, flag updates and FSM next state.
  always_comb begin
    in_ready    = (state_q == StIdle);
    busy        = (state_q == StMulBusy);
    accept      = in_valid && in_ready;
    rd_val      = regs_q[in_rd];
    rs_val      = regs_q[in_rs];
    sum         = {1'b0, rd_val} + {1'b0, rs_val};
    diff        = {1'b0, rd_val} - {1'b0, rs_val};
    state_d     = state_q;
    wr_en       = 1'b0;
    wr_idx      = in_rd;
    wr_data     = '0;
    z_d         = z_q;
    c_d         = c_q;
    err_d       = err_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    mul_start   = 1'b0;

    if (state_q == StMulBusy) begin
      if (mul_done) begin
        wr_en   = 1'b1;
        wr_idx  = mul_rd_q;
        wr_data = mul_product;
        z_d     = (mul_product == '0);
        state_d = StIdle;
      end
    end else if (accept) begin
      case (op_e'(in_op))
        OpNop: ;
        OpLi:  begin wr_en = 1'b1; wr_data = in_imm; end
        OpAdd: begin wr_en = 1'b1; wr_data = sum[DATA_W-1:0];  c_d = sum[DATA_W];  end
        OpSub: begin wr_en = 1'b1; wr_data = diff[DATA_W-1:0]; c_d = diff[DATA_W]; end
        OpAnd: begin wr_en = 1'b1; wr_data = rd_val & rs_val; end
        OpOr:  begin wr_en = 1'b1; wr_data = rd_val | rs_val; end
        OpXor: begin wr_en = 1'b1; wr_data = rd_val ^ rs_val; end
        OpShl: begin wr_en = 1'b1; wr_data = rd_val << 1; c_d = rd_val[DATA_W-1]; end
        OpMul: begin mul_start = 1'b1; state_d = StMulBusy; end
        OpOut: begin out_data_d = rd_val; out_valid_d = 1'b1; end
        default: err_d = 1'b1;
      endcase
      // Zero flag follows every register-writing op except LI.
      if (wr_en && op_e'(in_op) != OpLi) z_d = (wr_data == '0);
    end
  end

  // Architectural state; reset aborts any multiply in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      err_q       <= 1'b0;
      mul_rd_q    <= '0;
    end else begin
      state_q     <= state_d;
      if (wr_en) regs_q[wr_idx] <= wr_data;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      z_q         <= z_d;
      c_q         <= c_d;
      err_q       <= err_d;
      if (mul_start) mul_rd_q <= in_rd;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign err       = err_q;

endmodule
